// File: rtl/arima_pkg.sv
// Shared ARIMA pipeline definitions: control encoding and default formats.
// Used by the differencing stage and the AR/MA filter stages.
package arima_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'b00,
        CTRL_STALL = 2'b01,
        CTRL_INIT  = 2'b10,
        CTRL_CLR   = 2'b11
    } ctrl_e;

    localparam int Q_DEFAULT = 15;
    localparam int N_DEFAULT = 32;

endpackage

// File: rtl/qsub.sv
// Combinational signed subtract c = a_in - b_in with overflow detect.
// Saturates on overflow when DIFF_SAT_EN is defined, otherwise wraps.
module qsub
    import arima_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic signed [N-1:0] a_in,
    input  logic signed [N-1:0] b_in,
    output logic signed [N-1:0] c,
    output logic                ovr
);

    logic signed [N-1:0] w_diff;

    // Subtract, flag sign overflow, then wrap or clamp toward the minuend sign
    always_comb begin
        w_diff = a_in - b_in;
        ovr    = (a_in[N-1] != b_in[N-1]) && (w_diff[N-1] != a_in[N-1]);
`ifdef DIFF_SAT_EN
        if (ovr) begin
            c = a_in[N-1] ? {1'b1, {(N-1){1'b0}}}
                          : {1'b0, {(N-1){1'b1}}};
        end else begin
            c = w_diff;
        end
`else
        c = w_diff;
`endif
    end

endmodule

// File: rtl/diff_n.sv
// d-th order differencing stage feeding the AR filter, valid/ready streaming.
// Optional macro DIFF_SAT_EN: saturate overflowing differences instead of wrapping.
module diff_n
    import arima_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int Q     = Q_DEFAULT,
    parameter int D_MAX = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   control,
    input  logic [$clog2(D_MAX+1)-1:0]   d_order_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [N-1:0]          data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [N-1:0]          data_out,
    output logic                         warm,
    output logic                         overflow
);

    localparam int DW = $clog2(D_MAX + 1);

    if (Q < 0 || Q >= N) begin : g_q_chk
        $error("diff_n: Q must lie in [0, N-1]");
    end

    ctrl_e                 w_ctrl;
    logic                  w_accept;
    logic signed [N-1:0]   w_y [D_MAX+1];
    logic [D_MAX-1:0]      w_ovr;
    logic                  w_ovr_any;
    logic [DW-1:0]         w_ord_in;
    logic [DW-1:0]         w_cnt_nxt;
    logic [DW-1:0]         w_ord_nxt;

    logic signed [N-1:0]   r_prev [D_MAX];
    logic [DW-1:0]         r_warm_cnt;
    logic [DW-1:0]         r_d_order;
    logic signed [N-1:0]   r_data_out;
    logic                  r_out_valid;
    logic                  r_overflow;
    logic                  r_warm;

    assign w_ctrl   = ctrl_e'(control);
    assign in_ready = rst_n && (w_ctrl == CTRL_RUN)
                      && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_y[0]   = data_in;
    assign w_ord_in = (d_order_in > DW'(D_MAX)) ? DW'(D_MAX) : d_order_in;

    // Difference chain: stage k produces y_{k+1} = y_k - prev[k]
    for (genvar k = 0; k < D_MAX; k++) begin : g_chain
        qsub #(.N(N)) u_qsub (
            .a_in (w_y[k]),
            .b_in (r_prev[k]),
            .c    (w_y[k+1]),
            .ovr  (w_ovr[k])
        );
    end

    // Only stages inside the active order can raise overflow
    always_comb begin
        w_ovr_any = 1'b0;
        for (int k = 0; k < D_MAX; k++) begin
            if (DW'(k) < r_d_order && w_ovr[k]) begin
                w_ovr_any = 1'b1;
            end
        end
    end

    // Next warm-up count and order, shared by the warm flag register
    always_comb begin
        w_cnt_nxt = r_warm_cnt;
        w_ord_nxt = r_d_order;
        unique case (w_ctrl)
            CTRL_CLR: begin
                w_cnt_nxt = '0;
                w_ord_nxt = '0;
            end
            CTRL_INIT: begin
                w_cnt_nxt = '0;
                w_ord_nxt = w_ord_in;
            end
            CTRL_RUN: begin
                if (w_accept && r_warm_cnt < r_d_order) begin
                    w_cnt_nxt = r_warm_cnt + DW'(1);
                end
            end
            CTRL_STALL: begin
            end
        endcase
    end

    // Warm-up bookkeeping and registered warm flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm_cnt <= '0;
            r_d_order  <= '0;
            r_warm     <= 1'b0;
        end else begin
            r_warm_cnt <= w_cnt_nxt;
            r_d_order  <= w_ord_nxt;
            r_warm     <= (w_cnt_nxt == w_ord_nxt);
        end
    end

    // History, output register and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < D_MAX; k++) r_prev[k] <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            unique case (w_ctrl)
                CTRL_CLR: begin
                    for (int k = 0; k < D_MAX; k++) r_prev[k] <= '0;
                    r_data_out  <= '0;
                    r_out_valid <= 1'b0;
                    r_overflow  <= 1'b0;
                end
                CTRL_INIT: begin
                    for (int k = 0; k < D_MAX; k++) r_prev[k] <= '0;
                    r_out_valid <= 1'b0;
                end
                CTRL_STALL: begin
                    if (r_out_valid && out_ready) r_out_valid <= 1'b0;
                end
                CTRL_RUN: begin
                    if (w_accept) begin
                        for (int k = 0; k < D_MAX; k++) begin
                            if (DW'(k) < r_d_order) r_prev[k] <= w_y[k];
                        end
                        if (w_ovr_any) r_overflow <= 1'b1;
                        if (r_warm_cnt < r_d_order) begin
                            r_out_valid <= 1'b0;
                        end else begin
                            r_data_out  <= w_y[r_d_order];
                            r_out_valid <= 1'b1;
                        end
                    end else if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign warm      = r_warm;

endmodule

// File: tb/tb_diff_n.sv
// Directed self-checking bench for diff_n with hand-computed vectors.
// Expected saturated/wrapped results follow DIFF_SAT_EN.
module tb_diff_n;

    logic               clk;
    logic               rst_n;
    logic [1:0]         control;
    logic [1:0]         d_order_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] data_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] data_out;
    logic               warm;
    logic               overflow;

    int n_total;
    int n_pass;

    diff_n #(.N(32), .Q(15), .D_MAX(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .control    (control),
        .d_order_in (d_order_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .warm       (warm),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x);
        in_valid = 1'b1;
        data_in  = x;
        step();
        in_valid = 1'b0;
    endtask

    task automatic init(input logic [1:0] d);
        control    = 2'b10;
        d_order_in = d;
        step();
        control    = 2'b00;
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        control    = 2'b00;
        d_order_in = 2'd0;
        in_valid   = 1'b0;
        data_in    = '0;
        out_ready  = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_warm", {31'd0, warm}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;

        // first order
        init(2'd1);
        chk("t1_warm_init", {31'd0, warm}, 32'd0);
        send(32'd100);
        chk("t1_s0_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_s0_warm", {31'd0, warm}, 32'd1);
        send(32'd250);
        chk("t1_s1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_s1_data", data_out, 32'd150);
        send(32'd200);
        chk("t1_s2_data", data_out, 32'hFFFF_FFCE);
        step();
        chk("t1_drain", {31'd0, out_valid}, 32'd0);

        // second order on squares
        init(2'd2);
        send(32'd0);
        chk("t2_s0_valid", {31'd0, out_valid}, 32'd0);
        send(32'd1);
        chk("t2_s1_valid", {31'd0, out_valid}, 32'd0);
        send(32'd4);
        chk("t2_s2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_s2_data", data_out, 32'd2);
        send(32'd9);
        chk("t2_s3_data", data_out, 32'd2);
        send(32'd16);
        chk("t2_s4_data", data_out, 32'd2);
        step();

        // backpressure
        init(2'd1);
        send(32'd10);
        out_ready = 1'b0;
        send(32'd13);
        chk("t3_first", data_out, 32'd3);
        in_valid = 1'b1;
        data_in  = 32'd20;
        #1;
        chk("t3_in_ready_lo", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_data", data_out, 32'd3);
            chk("t3_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_in_ready_hi", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("t3_accept_data", data_out, 32'd7);
        chk("t3_accept_valid", {31'd0, out_valid}, 32'd1);
        step();
        chk("t3_drain", {31'd0, out_valid}, 32'd0);

        // overflow
        control = 2'b11;
        step();
        init(2'd1);
        send(32'h7FFF_FFFF);
        chk("t4_pre_ovf", {31'd0, overflow}, 32'd0);
        send(32'h8000_0000);
        chk("t4_ovf", {31'd0, overflow}, 32'd1);
`ifdef DIFF_SAT_EN
        chk("t4_data", data_out, 32'h8000_0000);
`else
        chk("t4_data", data_out, 32'h0000_0001);
`endif
        step();
        step();
        chk("t4_sticky", {31'd0, overflow}, 32'd1);
        control = 2'b11;
        step();
        control = 2'b00;
        chk("t4_clr_ovf", {31'd0, overflow}, 32'd0);
        chk("t4_clr_warm", {31'd0, warm}, 32'd1);

        // re-init mid-stream
        init(2'd2);
        send(32'd5);
        send(32'd8);
        send(32'd20);
        chk("t5_d2_data", data_out, 32'd9);
        out_ready = 1'b0;
        init(2'd1);
        chk("t5_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("t5_warm", {31'd0, warm}, 32'd0);
        out_ready = 1'b1;
        send(32'd100);
        chk("t5_s0_valid", {31'd0, out_valid}, 32'd0);
        send(32'd130);
        chk("t5_s1_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_s1_data", data_out, 32'd30);

        // async reset mid-stream
        send(32'd140);
        chk("t6_pre_data", data_out, 32'd10);
        send(32'h8000_0000);
        chk("t6_pre_ovf", {31'd0, overflow}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_data", data_out, 32'd0);
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_ovf", {31'd0, overflow}, 32'd0);
        chk("t6_rst_warm", {31'd0, warm}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("t6_warm_d0", {31'd0, warm}, 32'd1);
        send(32'd42);
        chk("t6_pass_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_pass_data", data_out, 32'd42);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
